// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and bit-timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // Clocks per bit period.
  function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 (idle level of a UART line).
module uart_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output; even-parity frames when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

  import uart_pkg::*;

  localparam int unsigned PulseWidth = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW       = cnt_width(PulseWidth);
  localparam int unsigned IdxW       = cnt_width(DATA_WIDTH);

  localparam logic [CntW-1:0] CntFull = CntW'(PulseWidth - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(PulseWidth / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  logic sig_s;

  uart_sync2 u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (sig),
    .q_o  (sig_s)
  );

  uart_rx_state_t        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic frame_good;
  logic frame_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic par_bad;
  logic parity_err_q, parity_err_d;
`endif

  // Receive FSM: half-bit into START lands every later sample mid-bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    par_bad    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!sig_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sig_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CntFull) begin
          cnt_d          = '0;
          shift_d[idx_q] = sig_s;
          if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          par_d   = sig_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (!sig_s) begin
            // Framing error wins over a parity mismatch.
            frame_bad = 1'b1;
            state_d   = WAIT_IDLE;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if ((^shift_q) != par_q) begin
              par_bad = 1'b1;
            end else begin
              frame_good = 1'b1;
            end
`else
            frame_good = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_IDLE: begin
        if (sig_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output holding register: a word arriving while the old one is unconsumed is dropped.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = frame_bad;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (frame_good) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err_d = par_bad;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the team's existing transmitter (uart_tx).
- Deserialises an 8N1 asynchronous line, LSB first: start bit 0, DATA_WIDTH data bits, stop bit 1.
- Presents each received word on a valid/ready handshake to the consuming logic.
- Sits at the chip boundary on the serial input. A loopback of uart_tx.sig into uart_rx.sig is the primary integration check.

Parameters:
DATA_WIDTH, 8, data bits per frame
BAUD_RATE, 9600, line bit rate in baud
CLK_FREQ, 100_000_000, clk frequency in Hz; PULSE_WIDTH = CLK_FREQ/BAUD_RATE clocks per bit (10416 at defaults)

Ports:
clk  input  1  system clock, all logic on posedge
rstn  input  1  reset; one clock; reset is asynchronous and active-low
sig  input  1  serial line, idle high, asynchronous to clk
data  output  DATA_WIDTH  received word, stable while valid=1
valid  output  1  data holds an unconsumed word
ready  input  1  consumer accepts data when valid&&ready on posedge
busy  output  1  1 in any state other than IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: frame completed while valid=1 and ready=0
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)

Behaviour:
- Reset values:
  - data=0, valid=0, busy=0, frame_err=0, overrun=0, parity_err=0.
  - Synchronizer flops=1, state=IDLE, bit counter=0, shift register=0.
  - Reset is async at any time, including mid-frame; the next frame after release is received normally.
- Input path: sig passes through a 2-flop synchronizer (sig_s). All decisions use sig_s only.
- Timing: a clock counter counts 0..limit-1 per phase.
- States and transitions:
  - IDLE: when sig_s==0, go to START and clear the counter.
  - START: count PULSE_WIDTH/2 clocks, then sample sig_s.
    - 0: go to DATA, counter=0, bit index=0.
    - 1: false start, go to IDLE with no flags.
  - DATA: every PULSE_WIDTH clocks, shift sig_s into the shift register at bit index (LSB first). After DATA_WIDTH samples go to STOP (or PARITY when enabled).
  - STOP: after PULSE_WIDTH clocks, sample sig_s.
    - 1: frame good, go to IDLE immediately (supports back-to-back frames with no idle gap).
    - 0: pulse frame_err, discard the word, go to WAIT_IDLE.
  - WAIT_IDLE: stay until sig_s==1, then go to IDLE. A break condition (line held low) produces exactly one frame_err.
- Output register on a good frame:
  - valid==0, or valid&&ready in the same cycle: load data, valid=1 on the next cycle.
  - valid==1 and ready==0: pulse overrun, drop the new word; the old data and valid are kept.
  - valid clears on the cycle after valid&&ready when no new word arrives in that cycle.
  - data never changes while valid=1 && ready=0.
- Latency: valid rises 1 clock after the stop-bit mid-sample, i.e. about 3 + PULSE_WIDTH*(DATA_WIDTH+1.5) clocks after the line falling edge.
- Tolerance: mid-bit sampling tolerates at least ±2% baud mismatch.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - PARITY state between DATA and STOP; frame is start + data + even-parity bit + stop.
  - Parity is sampled PULSE_WIDTH after the last data bit.
  - On mismatch: parity_err pulses at the stop-bit sample and the word is discarded (no valid).
  - Frame error takes precedence when both occur (only frame_err pulses).
- Undefined: no PARITY state; parity_err is a constant 0; port list is unchanged.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}.
  - Function pulse_width(clk_freq, baud_rate).
  - Localparam-style helper for counter width: $clog2(PULSE_WIDTH).
- One sub-module uart_sync2: 2-flop synchronizer with reset value 1, reused by any async input.

Test Plan:
All cases use default parameters (PULSE_WIDTH=10416) unless noted.
1. Drive 0xA5 with ready=1 -> valid=1 for one cycle, data=0xA5 about 98,955 clocks after the falling edge; no flags.
2. Low glitch of 2000 clocks on an idle line -> no valid, busy returns to 0, no frame_err.
3. Frame 0x3C with stop bit driven 0, then line high, then frame 0x5A -> one frame_err pulse, no valid for 0x3C; data=0x5A received.
4. ready=0, back-to-back frames 0x11 then 0x22 -> data stays 0x11 with valid held; one overrun pulse at the 0x22 stop sample. Then ready=1 -> 0x11 consumed, valid=0.
5. rstn low during data bit 4 of 0xC3 -> all outputs 0 immediately; after release, frame 0xFF -> data=0xFF, no flags.
6. Loopback uart_tx->uart_rx, sweep 0x00..0xFF with ready=1 -> 256 valid words, all match, zero flags. With UART_RX_PARITY_EN, also inject a flipped parity on 0x01 -> parity_err pulse, no valid.
